calc_operand_writer: RTL and testbench

Byte-stream front end for the calc_ops arithmetic units. It collects serial bytes from the host link and assembles them into two signed operands, A then B. It writes each pair into the operand FIFO that the subtractor (and sibling ops) drain, and writes both words of a pair on consecutive cycles, so a consumer that starts popping on `empty` deassertion always finds the second operand ready.

---
 rtl/calc_operand_writer.sv | 90 +++++++++
 tb/tb_calc_operand_writer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/calc_operand_writer.sv
// calc_operand_writer: assembles MSB-first byte stream into signed A/B operand pairs and writes them to the operand FIFO (optional OPERAND_CHECKSUM_EN)
module calc_operand_writer #(
  parameter int RAH_PACKET_WIDTH = 48
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  input  logic                        afull,
  output logic [RAH_PACKET_WIDTH-1:0] wr_data,
  output logic                        wren
`ifdef OPERAND_CHECKSUM_EN
  ,
  output logic                        csum_err
`endif
);
  localparam int W = RAH_PACKET_WIDTH;
  localparam int BYTES = W / 8;
`ifdef OPERAND_CHECKSUM_EN
  localparam int LAST = 2 * BYTES;
`else
  localparam int LAST = 2 * BYTES - 1;
`endif
  localparam int CW = $clog2(LAST + 1);
  typedef enum logic [1:0] {COLLECT, WAIT_SPACE, WR_A, WR_B} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] asm_q, asm_d;
  logic [W-1:0] wr_data_q, wr_data_d;
  logic rx_ready_q, rx_ready_d, wren_q, wren_d;
  logic fire, last, ok, shift;
`ifdef OPERAND_CHECKSUM_EN
  logic csum_err_q, csum_err_d;
  logic [7:0] sum;
  always_comb begin
    sum = '0;
    for (int i = 0; i < 2 * BYTES; i++) sum = sum ^ asm_q[i*8 +: 8];
  end
  assign ok = sum == rx_data;
  assign shift = fire && !last;
  assign csum_err = csum_err_q;
`else
  assign ok = 1'b1;
  assign shift = fire;
`endif
  assign fire = rx_valid && rx_ready_q;
  assign last = cnt_q == CW'(LAST);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q <= '0;
      asm_q <= '0;
      wr_data_q <= '0;
      rx_ready_q <= 1'b0;
      wren_q <= 1'b0;
`ifdef OPERAND_CHECKSUM_EN
      csum_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      asm_q <= asm_d;
      wr_data_q <= wr_data_d;
      rx_ready_q <= rx_ready_d;
      wren_q <= wren_d;
`ifdef OPERAND_CHECKSUM_EN
      csum_err_q <= csum_err_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q == COLLECT ? (fire && last && ok ? WAIT_SPACE : COLLECT) :
              state_q == WAIT_SPACE ? (afull ? WAIT_SPACE : WR_A) :
              state_q == WR_A ? WR_B : COLLECT;
    cnt_d = fire ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    asm_d = shift ? {asm_q[2*W-9:0], rx_data} : asm_q;
  end
  always_comb begin
    rx_ready_d = state_d == COLLECT;
    wren_d = state_d == WR_A || state_d == WR_B;
    wr_data_d = state_d == WR_A ? asm_q[2*W-1:W] : state_d == WR_B ? asm_q[W-1:0] : wr_data_q;
`ifdef OPERAND_CHECKSUM_EN
    csum_err_d = fire && last && !ok;
`endif
  end
  assign rx_ready = rx_ready_q;
  assign wren = wren_q;
  assign wr_data = wr_data_q;
endmodule

// File: tb/tb_calc_operand_writer.sv
// tb_calc_operand_writer: table-driven, directed and random checks of calc_operand_writer against a queue model
module tb_calc_operand_writer;
  localparam int W = 48;
  localparam int BYTES = W / 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_valid = 1'b0;
  logic afull = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_ready, wren;
  logic [W-1:0] wr_data;
`ifdef OPERAND_CHECKSUM_EN
  logic csum_err;
`endif
  int errors = 0;
  int checks = 0;
  logic [W-1:0] expq[$];
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic signed [W-1:0] ea;
    logic signed [W-1:0] eb;
    int h;
    bit gap;
  } vec_t;
  vec_t tbl[6];
  calc_operand_writer #(.RAH_PACKET_WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .afull(afull),
    .wr_data(wr_data),
    .wren(wren)
`ifdef OPERAND_CHECKSUM_EN
    ,
    .csum_err(csum_err)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && wren) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %h expected none", wr_data);
      end else chk("wr_data", wr_data, expq.pop_front());
    end
  end
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b, input bit gap, input bit bad);
    logic [2*W-1:0] f;
    logic [7:0] x;
    f = {a, b};
    x = '0;
    for (int i = 2 * BYTES - 1; i >= 0; i--) begin
      if (gap && i != 2 * BYTES - 1) @(negedge clk);
      x = x ^ f[i*8 +: 8];
      send_byte(f[i*8 +: 8]);
    end
`ifdef OPERAND_CHECKSUM_EN
    if (gap) @(negedge clk);
    send_byte(bad ? x ^ 8'h09 : x);
`else
    if (bad) x = '0;
`endif
  endtask
  task automatic run_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] ea,
                          input logic [W-1:0] eb, input int h, input bit gap);
    int low = 0;
    expq.push_back(ea);
    expq.push_back(eb);
    afull = h > 0;
    send_frame(a, b, gap, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (i == h) afull = 1'b0;
      if (rx_ready) break;
      if (i <= h) chk("no_wren_while_waiting", W'(wren), '0);
      low++;
      @(negedge clk);
    end
    afull = 1'b0;
    chk("rx_ready_gap", W'(low), W'(3 + h));
    chk("wren_low_in_collect", W'(wren), '0);
    chk("pair_written", W'(expq.size()), '0);
  endtask
  initial begin
    logic [63:0] r0, r1;
    tbl[0] = '{48'h00000000000A, 48'h000000000003, 48'sd10, 48'sd3, 0, 1'b0};
    tbl[1] = '{48'hFFFFFFFFFFFB, 48'h000000000007, -48'sd5, 48'sd7, 0, 1'b0};
    tbl[2] = '{48'h00000000000A, 48'h000000000003, 48'sd10, 48'sd3, 5, 1'b0};
    tbl[3] = '{48'h00000000000A, 48'h000000000003, 48'sd10, 48'sd3, 0, 1'b1};
    tbl[4] = '{48'h800000000000, 48'h7FFFFFFFFFFF, -48'sd140737488355328, 48'sd140737488355327, 1, 1'b0};
    tbl[5] = '{48'h123456789ABC, 48'hFEDCBA987654, 48'sd20015998343868, -48'sd1250999896492, 2, 1'b1};
    repeat (3) @(negedge clk);
    chk("reset_wren", W'(wren), '0);
    chk("reset_wr_data", wr_data, '0);
    chk("reset_rx_ready", W'(rx_ready), '0);
`ifdef OPERAND_CHECKSUM_EN
    chk("reset_csum_err", W'(csum_err), '0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("rx_ready_after_reset", W'(rx_ready), W'(1));
    for (int i = 0; i < 6; i++) run_pair(tbl[i].a, tbl[i].b, tbl[i].ea, tbl[i].eb, tbl[i].h, tbl[i].gap);
    for (int i = 0; i < 4; i++) send_byte(8'hA5);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_wren", W'(wren), '0);
    chk("midreset_wr_data", wr_data, '0);
    chk("midreset_rx_ready", W'(rx_ready), '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rx_ready_after_midreset", W'(rx_ready), W'(1));
    run_pair(48'h000000000021, 48'h000000000042, 48'sd33, 48'sd66, 0, 1'b0);
`ifdef OPERAND_CHECKSUM_EN
    send_frame(48'h00000000000A, 48'h000000000003, 1'b0, 1'b1);
    chk("csum_err_pulse", W'(csum_err), W'(1));
    chk("csum_rx_ready", W'(rx_ready), W'(1));
    chk("csum_no_wren", W'(wren), '0);
    @(negedge clk);
    chk("csum_err_one_cycle", W'(csum_err), '0);
    chk("csum_no_wren_after", W'(wren), '0);
    run_pair(48'h00000000000A, 48'h000000000003, 48'sd10, 48'sd3, 0, 1'b0);
`endif
    for (int n = 0; n < 20; n++) begin
      r0 = {$urandom(), $urandom()};
      r1 = {$urandom(), $urandom()};
      run_pair(r0[W-1:0], r1[W-1:0], r0[W-1:0], r1[W-1:0], int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    repeat (4) @(negedge clk);
    chk("final_queue_empty", W'(expq.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
